// File: rtl/dec_lag3_fsm.sv
// G.729 decoder pitch-lag decode (integer lag + fraction in thirds).
// Optional DEC_LAG3_RANGE_OUT_EN exposes the T0_min/T0_max search window.
module dec_lag3_fsm #(
  parameter logic [15:0] MULT_K    = 16'd10923,
  parameter logic [15:0] SF0_SPLIT = 16'd197
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] index,
  input  logic        i_subfr,
  input  logic [15:0] PIT_MIN,
  input  logic [15:0] PIT_MAX,
  output logic [15:0] T0,
  output logic [15:0] T0_frac,
`ifdef DEC_LAG3_RANGE_OUT_EN
  output logic [15:0] T0_min_out,
  output logic [15:0] T0_max_out,
`endif
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_RNG_MIN,
    S_RNG_MAX,
    S_FIN,
    S_DONE
  } state_t;

  function automatic logic [15:0] f_sat(
    input logic signed [16:0] s
  );
    if (s > 17'sd32767)
      return 16'h7FFF;
    else if (s < -17'sd32768)
      return 16'h8000;
    return s[15:0];
  endfunction

  function automatic logic [15:0] f_add(
    input logic [15:0] a,
    input logic [15:0] b
  );
    return f_sat($signed({a[15], a}) + $signed({b[15], b}));
  endfunction

  function automatic logic [15:0] f_sub(
    input logic [15:0] a,
    input logic [15:0] b
  );
    return f_sat($signed({a[15], a}) - $signed({b[15], b}));
  endfunction

  function automatic logic [15:0] f_mul3(
    input logic [15:0] x
  );
    return f_add(f_add(x, x), x);
  endfunction

  // Q15 product shifted back to Q0, clipped like the G.729 mult op
  function automatic logic [15:0] f_q15(
    input logic signed [31:0] p
  );
    logic signed [31:0] v;
    v = p >>> 15;
    if (v > 32'sd32767)
      return 16'h7FFF;
    else if (v < -32'sd32768)
      return 16'h8000;
    return v[15:0];
  endfunction

  state_t             r_state;
  logic [15:0]        r_index;
  logic               r_subfr;
  logic signed [31:0] r_prod;
  logic [15:0]        r_t0;
  logic [15:0]        r_t0_frac;
  logic [15:0]        r_t0_min;
  logic [15:0]        r_t0_max;
  logic               r_done;

  logic [15:0]        w_idx2;
  logic signed [31:0] w_prod;
  logic [15:0]        w_q;
  logic [15:0]        w_min_pre;
  logic [15:0]        w_max_pre;
  logic [15:0]        w_t0_a;
  logic [15:0]        w_frac_a;
  logic [15:0]        w_i;
  logic [15:0]        w_t0_b;
  logic [15:0]        w_frac_b;
  logic               w_lo_branch;

  assign w_idx2 = f_add(r_index, 16'd2);
  assign w_prod = $signed({{16{w_idx2[15]}}, w_idx2})
                * $signed({{16{MULT_K[15]}}, MULT_K});
  assign w_q    = f_q15(r_prod);

  assign w_min_pre = f_sub(r_t0, 16'd5);
  assign w_max_pre = f_add(r_t0_min, 16'd9);

  assign w_lo_branch = $signed(r_index) < $signed(SF0_SPLIT);
  assign w_t0_a   = w_lo_branch ? f_add(w_q, 16'd19)
                                : f_sub(r_index, 16'd112);
  assign w_frac_a = w_lo_branch
                  ? f_add(f_sub(r_index, f_mul3(w_t0_a)), 16'd58)
                  : 16'd0;

  assign w_i      = f_sub(w_q, 16'd1);
  assign w_t0_b   = f_add(w_i, r_t0_min);
  assign w_frac_b = f_sub(f_sub(r_index, 16'd2), f_mul3(w_i));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_index   <= '0;
      r_subfr   <= 1'b0;
      r_prod    <= '0;
      r_t0      <= '0;
      r_t0_frac <= '0;
      r_t0_min  <= '0;
      r_t0_max  <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_index <= index;
            r_subfr <= i_subfr;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_prod  <= w_prod;
          r_state <= r_subfr ? S_RNG_MIN : S_FIN;
        end
        S_RNG_MIN: begin
          if ($signed(w_min_pre) < $signed(PIT_MIN))
            r_t0_min <= PIT_MIN;
          else
            r_t0_min <= w_min_pre;
          r_state <= S_RNG_MAX;
        end
        S_RNG_MAX: begin
          if ($signed(w_max_pre) > $signed(PIT_MAX)) begin
            r_t0_max <= PIT_MAX;
            r_t0_min <= f_sub(PIT_MAX, 16'd9);
          end else begin
            r_t0_max <= w_max_pre;
          end
          r_state <= S_FIN;
        end
        S_FIN: begin
          r_t0      <= r_subfr ? w_t0_b : w_t0_a;
          r_t0_frac <= r_subfr ? w_frac_b : w_frac_a;
          r_done    <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign T0      = r_t0;
  assign T0_frac = r_t0_frac;
  assign done    = r_done;
`ifdef DEC_LAG3_RANGE_OUT_EN
  assign T0_min_out = r_t0_min;
  assign T0_max_out = r_t0_max;
`endif

endmodule

// File: tb/tb_dec_lag3_fsm.sv
// Directed bench for dec_lag3_fsm: lag values, window clamps,
// latency, reset abort and start filtering.
module tb_dec_lag3_fsm;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] index;
  logic        i_subfr;
  logic [15:0] PIT_MIN = 16'd20;
  logic [15:0] PIT_MAX = 16'd143;
  logic [15:0] T0;
  logic [15:0] T0_frac;
  logic        done;
`ifdef DEC_LAG3_RANGE_OUT_EN
  logic [15:0] T0_min_out;
  logic [15:0] T0_max_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  dec_lag3_fsm dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .index   (index),
    .i_subfr (i_subfr),
    .PIT_MIN (PIT_MIN),
    .PIT_MAX (PIT_MAX),
    .T0      (T0),
    .T0_frac (T0_frac),
`ifdef DEC_LAG3_RANGE_OUT_EN
    .T0_min_out (T0_min_out),
    .T0_max_out (T0_max_out),
`endif
    .done    (done)
  );

  // Issue one decode; returns outputs seen with done, the cycle of
  // done (1 = cycle right after the start edge) and the next-cycle done.
  task automatic run_decode(
    input  logic [15:0] idx,
    input  logic        sf,
    output logic [15:0] t0,
    output logic [15:0] frac,
    output int          cyc,
    output logic        done_after
  );
    @(negedge clock);
    start = 1'b1;
    index = idx;
    i_subfr = sf;
    @(posedge clock);
    #1;
    start = 1'b0;
    index = 16'hBEEF;
    i_subfr = ~sf;
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    t0 = T0;
    frac = T0_frac;
    @(posedge clock);
    #1;
    done_after = done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    index = 16'd0;
    i_subfr = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    n_tests++;
    if (T0 !== 16'd0 || T0_frac !== 16'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: T0=%h frac=%h done=%b, want 0/0/0",
               T0, T0_frac, done);
    end
`ifdef DEC_LAG3_RANGE_OUT_EN
    n_tests++;
    if (T0_min_out !== 16'd0 || T0_max_out !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_win: min=%h max=%h, want 0/0",
               T0_min_out, T0_max_out);
    end
`endif
  endtask

  task automatic test_sf0();
    logic [15:0] v_idx [4] = '{16'd0, 16'd196, 16'd197, 16'd255};
    logic [15:0] v_t0  [4] = '{16'd19, 16'd85, 16'd85, 16'd143};
    logic [15:0] v_fr  [4] = '{16'd1, 16'hFFFF, 16'd0, 16'd0};
    logic [15:0] t0, fr;
    int cyc;
    logic da;
    for (int k = 0; k < 4; k++) begin
      run_decode(v_idx[k], 1'b0, t0, fr, cyc, da);
      n_tests++;
      if (t0 !== v_t0[k] || fr !== v_fr[k]) begin
        n_fail++;
        $display("FAIL sf0 idx=%0d: T0=%h frac=%h, want %h/%h",
                 v_idx[k], t0, fr, v_t0[k], v_fr[k]);
      end
      n_tests++;
      if (cyc !== 3 || da !== 1'b0) begin
        n_fail++;
        $display("FAIL sf0_lat idx=%0d: cycle=%0d after=%b, want 3/0",
                 v_idx[k], cyc, da);
      end
    end
    n_tests++;
    if (T0 !== 16'd143 || T0_frac !== 16'd0) begin
      n_fail++;
      $display("FAIL sf0_hold: T0=%h frac=%h, want 008f/0000",
               T0, T0_frac);
    end
  endtask

  task automatic test_sf1();
    logic [15:0] t0, fr;
    int cyc;
    logic da;
    run_decode(16'd196, 1'b0, t0, fr, cyc, da);
    run_decode(16'd13, 1'b1, t0, fr, cyc, da);
    n_tests++;
    if (t0 !== 16'd84 || fr !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sf1_13: T0=%h frac=%h, want 0054/ffff", t0, fr);
    end
    n_tests++;
    if (cyc !== 5 || da !== 1'b0) begin
      n_fail++;
      $display("FAIL sf1_lat: cycle=%0d after=%b, want 5/0", cyc, da);
    end
`ifdef DEC_LAG3_RANGE_OUT_EN
    n_tests++;
    if (T0_min_out !== 16'd80 || T0_max_out !== 16'd89) begin
      n_fail++;
      $display("FAIL sf1_win: min=%0d max=%0d, want 80/89",
               T0_min_out, T0_max_out);
    end
`endif
    run_decode(16'd196, 1'b0, t0, fr, cyc, da);
    run_decode(16'd0, 1'b1, t0, fr, cyc, da);
    n_tests++;
    if (t0 !== 16'd79 || fr !== 16'd1) begin
      n_fail++;
      $display("FAIL sf1_0: T0=%h frac=%h, want 004f/0001", t0, fr);
    end
  endtask

  task automatic test_clamps();
    logic [15:0] t0, fr;
    int cyc;
    logic da;
    run_decode(16'd255, 1'b0, t0, fr, cyc, da);
    run_decode(16'd31, 1'b1, t0, fr, cyc, da);
    n_tests++;
    if (t0 !== 16'd144 || fr !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL clamp_hi: T0=%h frac=%h, want 0090/ffff", t0, fr);
    end
`ifdef DEC_LAG3_RANGE_OUT_EN
    n_tests++;
    if (T0_min_out !== 16'd134 || T0_max_out !== 16'd143) begin
      n_fail++;
      $display("FAIL clamp_hi_win: min=%0d max=%0d, want 134/143",
               T0_min_out, T0_max_out);
    end
`endif
    run_decode(16'd0, 1'b0, t0, fr, cyc, da);
    run_decode(16'd0, 1'b1, t0, fr, cyc, da);
    n_tests++;
    if (t0 !== 16'd19 || fr !== 16'd1) begin
      n_fail++;
      $display("FAIL clamp_lo: T0=%h frac=%h, want 0013/0001", t0, fr);
    end
`ifdef DEC_LAG3_RANGE_OUT_EN
    n_tests++;
    if (T0_min_out !== 16'd20 || T0_max_out !== 16'd29) begin
      n_fail++;
      $display("FAIL clamp_lo_win: min=%0d max=%0d, want 20/29",
               T0_min_out, T0_max_out);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [15:0] t0, fr;
    int cyc;
    int n_done;
    logic da;
    run_decode(16'd196, 1'b0, t0, fr, cyc, da);
    @(negedge clock);
    start = 1'b1;
    index = 16'd13;
    i_subfr = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    n_tests++;
    if (T0 !== 16'd0 || T0_frac !== 16'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: T0=%h frac=%h done=%b, want 0/0/0",
               T0, T0_frac, done);
    end
    n_done = 0;
    repeat (8) begin
      @(posedge clock);
      #1;
      if (done === 1'b1) n_done++;
    end
    n_tests++;
    if (n_done !== 0) begin
      n_fail++;
      $display("FAIL reset_abort: done pulses=%0d, want 0", n_done);
    end
    run_decode(16'd0, 1'b1, t0, fr, cyc, da);
    n_tests++;
    if (t0 !== 16'd19 || fr !== 16'd1 || cyc !== 5) begin
      n_fail++;
      $display("FAIL post_reset_sf1: T0=%h frac=%h cyc=%0d, want 0013/0001/5",
               t0, fr, cyc);
    end
  endtask

  task automatic test_start_in_mul();
    int n_done;
    @(negedge clock);
    start = 1'b1;
    index = 16'd0;
    i_subfr = 1'b0;
    @(posedge clock);
    #1;
    index = 16'd255;
    @(posedge clock);
    #1;
    start = 1'b0;
    n_done = 0;
    repeat (10) begin
      if (done === 1'b1) n_done++;
      @(posedge clock);
      #1;
    end
    n_tests++;
    if (n_done !== 1 || T0 !== 16'd19 || T0_frac !== 16'd1) begin
      n_fail++;
      $display("FAIL start_in_mul: dones=%0d T0=%h frac=%h, want 1/0013/0001",
               n_done, T0, T0_frac);
    end
  endtask

  task automatic test_start_in_done();
    int n_done;
    @(negedge clock);
    start = 1'b1;
    index = 16'd197;
    i_subfr = 1'b0;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    start = 1'b1;
    index = 16'd0;
    n_done = (done === 1'b1) ? 1 : 0;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (8) begin
      @(posedge clock);
      #1;
      if (done === 1'b1) n_done++;
    end
    n_tests++;
    if (n_done !== 1 || T0 !== 16'd85 || T0_frac !== 16'd0) begin
      n_fail++;
      $display("FAIL start_in_done: dones=%0d T0=%h frac=%h, want 1/0055/0000",
               n_done, T0, T0_frac);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] t0, fr;
    int cyc;
    logic da;
    run_decode(16'd0, 1'b0, t0, fr, cyc, da);
    run_decode(16'd200, 1'b0, t0, fr, cyc, da);
    n_tests++;
    if (t0 !== 16'd88 || fr !== 16'd0 || cyc !== 3) begin
      n_fail++;
      $display("FAIL back_to_back: T0=%h frac=%h cyc=%0d, want 0058/0000/3",
               t0, fr, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_sf0();
    test_sf1();
    test_clamps();
    test_reset_mid();
    test_start_in_mul();
    test_start_in_done();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
